// File: rtl/restock_pkg.sv
// Shared types and constants for the restock arbiter and its round-robin picker.
// Quantities are 6-bit; anything above STOCK_CAP is clamped before reaching the supplier.
package restock_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      ACK  = 2'd2
   } state_e;

   localparam int   NUM_W     = 6;
   localparam int   STOCK_CAP = 50;
   localparam logic PROD_A    = 1'b1;   // nugget / apple
   localparam logic PROD_B    = 1'b0;   // fried rice / peach

   function automatic logic [NUM_W-1:0] clamp_num(input logic [NUM_W-1:0] n);
      return (n > NUM_W'(STOCK_CAP)) ? NUM_W'(STOCK_CAP) : n;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req_i searching upward from ptr_i with wrap.
// No state, zero latency.
module rr_pick #(
   parameter  int NUM_REQ = 4,
   localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDW-1:0]     ptr_i,
   output logic [IDW-1:0]     gnt_idx_o,
   output logic               any_vld_o
);

   logic [IDW-1:0] idx;

   // Walk offsets from farthest to nearest so the closest requester at or after ptr_i wins.
   always_comb begin
      gnt_idx_o = '0;
      any_vld_o = 1'b0;
      idx       = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = IDW'((int'(ptr_i) + k) % NUM_REQ);
         if (req_i[idx]) begin
            gnt_idx_o = idx;
            any_vld_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/restock_arbiter.sv
// Round-robin arbiter sharing one restock supplier port between NUM_REQ stores; grant -> REQ -> ACK.
// Optional RESTOCK_TIMEOUT_EN aborts a supplier wait after TIMEOUT_CYC cycles and pulses err_timeout.
module restock_arbiter
   import restock_pkg::*;
#(
   parameter  int NUM_REQ     = 4,
   parameter  int TIMEOUT_CYC = 63,
   localparam int IDW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ-1:0]       req_product,
   input  logic [NUM_W*NUM_REQ-1:0] req_number,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     sup_valid,
   output logic                     sup_product,
   output logic [NUM_W-1:0]         sup_number,
   output logic [IDW-1:0]           sup_id,
   input  logic                     sup_ready,
   output logic                     busy,
   output logic                     err_timeout
);

   state_e           state_q, state_d;
   logic             prod_q, prod_d;
   logic [NUM_W-1:0] num_q, num_d;
   logic [IDW-1:0]   id_q, id_d;
   logic [IDW-1:0]   rr_q, rr_d;
   logic [IDW-1:0]   next_rr;
   logic [IDW-1:0]   pick_idx;
   logic             pick_vld;
   logic [NUM_W-1:0] pick_num;

`ifdef RESTOCK_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
`endif

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req_i     (req_valid),
      .ptr_i     (rr_q),
      .gnt_idx_o (pick_idx),
      .any_vld_o (pick_vld)
   );

   assign pick_num = clamp_num(req_number[int'(pick_idx)*NUM_W +: NUM_W]);
   assign next_rr  = (id_q == IDW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;

   always_comb begin
      state_d = state_q;
      prod_d  = prod_q;
      num_d   = num_q;
      id_d    = id_q;
      rr_d    = rr_q;
`ifdef RESTOCK_TIMEOUT_EN
      cnt_d   = cnt_q;
      err_d   = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               prod_d  = req_product[pick_idx];
               id_d    = pick_idx;
               num_d   = pick_num;
               // A zero quantity needs no supplier traffic, only the ack.
               state_d = (pick_num != '0) ? REQ : ACK;
`ifdef RESTOCK_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         REQ: begin
            if (sup_ready) begin
               state_d = ACK;
`ifdef RESTOCK_TIMEOUT_EN
            end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
               state_d = IDLE;
               err_d   = 1'b1;
               rr_d    = next_rr;
            end else begin
               cnt_d   = cnt_q + 1'b1;
`endif
            end
         end
         ACK: begin
            rr_d    = next_rr;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         prod_q  <= 1'b0;
         num_q   <= '0;
         id_q    <= '0;
         rr_q    <= '0;
`ifdef RESTOCK_TIMEOUT_EN
         cnt_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         prod_q  <= prod_d;
         num_q   <= num_d;
         id_q    <= id_d;
         rr_q    <= rr_d;
`ifdef RESTOCK_TIMEOUT_EN
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`endif
      end
   end

   assign sup_valid   = (state_q == REQ);
   assign sup_product = prod_q;
   assign sup_number  = num_q;
   assign sup_id      = id_q;
   assign busy        = (state_q != IDLE);
   assign req_ready   = (state_q == ACK) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << id_q) : '0;

`ifdef RESTOCK_TIMEOUT_EN
   assign err_timeout = err_q;
`else
   assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_restock_arbiter.sv
// Scoreboard bench for restock_arbiter: directed scenarios then randomized request bursts.
// Expected grants come from a transaction-level round-robin model over the pending set.
module tb_restock_arbiter;

   localparam int N    = 4;
   localparam int CAP  = 50;
   localparam int TOUT = 63;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [N-1:0]   req_product = '0;
   logic [6*N-1:0] req_number = '0;
   logic [N-1:0]   req_ready;
   logic           sup_valid;
   logic           sup_product;
   logic [5:0]     sup_number;
   logic [1:0]     sup_id;
   logic           sup_ready = 1'b0;
   logic           busy;
   logic           err_timeout;

   restock_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TOUT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_product (req_product),
      .req_number  (req_number),
      .req_ready   (req_ready),
      .sup_valid   (sup_valid),
      .sup_product (sup_product),
      .sup_number  (sup_number),
      .sup_id      (sup_id),
      .sup_ready   (sup_ready),
      .busy        (busy),
      .err_timeout (err_timeout)
   );

   initial forever #5 clk = ~clk;

   typedef struct {int id; int prod; int num;} sup_t;
   typedef struct {int id; bit has_sup;} ack_t;

   sup_t exp_sup[$];
   ack_t exp_ack[$];
   int   ack_cyc[$];

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int last_hs = -10;
   int sup_mode = 0;    // 0 random, 1 always ready, 2 never ready
   bit expect_err = 1'b0;
   int m_rr = 0;        // model round-robin pointer

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(posedge clk);
      #2;
      case (sup_mode)
         1:       sup_ready = 1'b1;
         2:       sup_ready = 1'b0;
         default: sup_ready = ($urandom_range(0, 2) == 0);
      endcase
   end

   // Store behaviour: drop the request once acked.
   initial forever begin
      @(negedge clk);
      if (rst_n) req_valid = req_valid & ~req_ready;
   end

   // Monitor: compare every supplier handshake and every ack against the scoreboard.
   initial forever begin
      sup_t e;
      ack_t a;
      @(negedge clk);
      if (rst_n) begin
         if (sup_valid && sup_ready) begin
            if (exp_sup.size() == 0) check("unexpected_sup_handshake", 32'(sup_id), 32'hFFFF);
            else begin
               e = exp_sup.pop_front();
               check("sup_id", 32'(sup_id), e.id);
               check("sup_product", 32'(sup_product), e.prod);
               check("sup_number", 32'(sup_number), e.num);
            end
            last_hs = cyc;
         end
         if (req_ready != '0) begin
            check("req_ready_onehot", $countones(req_ready), 1);
            if (exp_ack.size() == 0) check("unexpected_ack", 32'(req_ready), 0);
            else begin
               a = exp_ack.pop_front();
               check("ack_id", 32'(req_ready), 32'(1) << a.id);
               if (a.has_sup) check("ack_latency", cyc - last_hs, 1);
            end
            ack_cyc.push_back(cyc);
         end
         if (!expect_err) check("err_timeout_quiet", 32'(err_timeout), 0);
      end
   end

   // Model: with all requests held until acked, service order is ascending from the pointer with wrap.
   task automatic issue(input logic [N-1:0] mask, input logic [N-1:0] prod,
                        input logic [6*N-1:0] num, input bit skip_first);
      int  last = -1;
      bit  first = 1'b1;
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (m_rr + k) % N;
         if (mask[idx]) begin
            int q;
            q = int'(num[idx*6 +: 6]);
            if (q > CAP) q = CAP;
            if (!(skip_first && first)) begin
               if (q != 0) exp_sup.push_back('{idx, int'(prod[idx]), q});
               exp_ack.push_back('{idx, q != 0});
            end
            first = 1'b0;
            last = idx;
         end
      end
      if (last >= 0) m_rr = (last + 1) % N;
      req_product = prod;
      req_number  = num;
      req_valid   = mask;
   endtask

   task automatic drain(input string name);
      int t = 0;
      while ((req_valid != '0 || busy) && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (t >= 400) begin
         check({name, "_drain_timeout"}, 32'(req_valid), 0);
         exp_sup.delete();
         exp_ack.delete();
         req_valid = '0;
      end
      @(posedge clk);
      #2;
   endtask

   task automatic wait_sup(input string name);
      int t = 0;
      while (!sup_valid && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) check({name, "_sup_wait"}, 32'(sup_valid), 1);
   endtask

   function automatic logic [5:0] pick_num();
      case ($urandom_range(0, 7))
         0:       return 6'd0;
         1:       return 6'd50;
         2:       return 6'd63;
         3:       return 6'd51;
         4:       return 6'd49;
         default: return 6'($urandom_range(0, 63));
      endcase
   endfunction

   initial begin
      logic [N-1:0]   rp;
      logic [6*N-1:0] rn;
      logic [N-1:0]   rm;
      int             cnt;

      repeat (2) @(posedge clk);
      #2;
      check("rst_sup_valid", 32'(sup_valid), 0);
      check("rst_sup_product", 32'(sup_product), 0);
      check("rst_sup_number", 32'(sup_number), 0);
      check("rst_sup_id", 32'(sup_id), 0);
      check("rst_req_ready", 32'(req_ready), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_err_timeout", 32'(err_timeout), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #2;

      // Contention with an always-ready supplier: grants 0,1,2,3 three cycles apart.
      sup_mode = 1;
      ack_cyc.delete();
      issue(4'hF, 4'b1010, {6'd9, 6'd30, 6'd50, 6'd1}, 1'b0);
      drain("contention");
      check("contention_ack_count", ack_cyc.size(), 4);
      for (int i = 1; i < 4 && i < ack_cyc.size(); i++)
         check("contention_ack_spacing", ack_cyc[i] - ack_cyc[i-1], 3);

      // Pointer back at 0: store 0 must win over store 3.
      issue(4'b1001, 4'b0001, {6'd12, 6'd0, 6'd0, 6'd7}, 1'b0);
      drain("ptr_wrap");

      // Single request with a supplier that answers three cycles late.
      sup_mode = 2;
      issue(4'b0100, 4'b0100, {6'd0, 6'd17, 6'd0, 6'd0}, 1'b0);
      wait_sup("single");
      check("single_sup_id_early", 32'(sup_id), 2);
      repeat (3) @(negedge clk);
      sup_mode = 1;
      drain("single");
      check("single_busy_after", 32'(busy), 0);

      // Zero quantity (store 3) and clamp 63 -> 50 (store 1).
      sup_mode = 0;
      issue(4'b1010, 4'b0010, {6'd0, 6'd0, 6'd63, 6'd0}, 1'b0);
      drain("clamp_zero");

      // Store 0 withdraws after grant; ack must still arrive.
      sup_mode = 2;
      issue(4'b0001, 4'b0000, {6'd0, 6'd0, 6'd0, 6'd40}, 1'b0);
      wait_sup("withdraw");
      check("withdraw_sup_id", 32'(sup_id), 0);
      req_valid[0] = 1'b0;
      repeat (2) @(negedge clk);
      sup_mode = 1;
      drain("withdraw");

      // Reset in the middle of a supplier request.
      sup_mode = 2;
      issue(4'b0100, 4'b0000, {6'd0, 6'd5, 6'd0, 6'd0}, 1'b0);
      wait_sup("midrst");
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_sup_valid", 32'(sup_valid), 0);
      check("midrst_sup_number", 32'(sup_number), 0);
      check("midrst_sup_id", 32'(sup_id), 0);
      check("midrst_req_ready", 32'(req_ready), 0);
      check("midrst_busy", 32'(busy), 0);
      exp_sup.delete();
      exp_ack.delete();
      req_valid = '0;
      m_rr = 0;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      sup_mode = 0;
      @(posedge clk);
      #2;
      issue(4'hF, 4'b0110, {6'd3, 6'd63, 6'd0, 6'd22}, 1'b0);
      drain("after_rst");

`ifdef RESTOCK_TIMEOUT_EN
      // Store 1 times out (no ack), store 2 is served next.
      sup_mode = 2;
      expect_err = 1'b1;
      issue(4'b0110, 4'b0110, {6'd0, 6'd21, 6'd20, 6'd0}, 1'b1);
      wait_sup("timeout");
      cnt = 0;
      while (sup_valid && cnt < 200) begin
         cnt++;
         @(negedge clk);
      end
      check("timeout_req_cycles", cnt, TOUT);
      check("timeout_err_pulse", 32'(err_timeout), 1);
      req_valid[1] = 1'b0;
      @(negedge clk);
      check("timeout_err_one_cycle", 32'(err_timeout), 0);
      expect_err = 1'b0;
      sup_mode = 1;
      drain("timeout");
`endif

      // Randomized bursts.
      for (int b = 0; b < 40; b++) begin
         sup_mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
         rm = 4'($urandom_range(1, 15));
         rp = 4'($urandom_range(0, 15));
         for (int i = 0; i < N; i++) rn[i*6 +: 6] = pick_num();
         issue(rm, rp, rn, 1'b0);
         drain("random");
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #2;
      end

      check("scoreboard_empty", exp_sup.size() + exp_ack.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/restock_arbiter.md
Name: restock_arbiter

Overview:
- Shares one restock supplier port (kitchen or refrigerator) between NUM_REQ store controllers.
- Each store raises a restock request of product plus quantity on a valid/ready pair. The arbiter grants round-robin, forwards the latched request to the supplier, waits for the supplier handshake, then acks the winning store.
- Sits between the store controllers and the supplier side of the AHB-style interconnect. One instance per supplier.

Parameters:
- NUM_REQ, 4, number of requesting stores (2..8); IDW = $clog2(NUM_REQ) is a derived localparam.
- STOCK_CAP, 50, maximum quantity forwarded per request.
- TIMEOUT_CYC, 63, supplier-wait limit (used only with RESTOCK_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  per-store restock request
- req_product  in  NUM_REQ  per-store product select (1 = nugget/apple, 0 = fried rice/peach)
- req_number  in  6*NUM_REQ  per-store quantity; store i occupies bits [6i+5:6i]
- req_ready  out  NUM_REQ  one-cycle completion ack to the granted store
- sup_valid  out  1  request to supplier
- sup_product  out  1  latched product select
- sup_number  out  6  latched, clamped quantity
- sup_id  out  IDW  index of the granted store
- sup_ready  in  1  supplier accept
- busy  out  1  high in every state except IDLE
- err_timeout  out  1  one-cycle pulse on supplier timeout

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer rr_ptr = 0, timeout counter 0.
- Reset mid-transaction discards the latched request and issues no ack. Stores must re-request.

States:
- IDLE:
  - If any req_valid is high, pick the first valid index searching upward from rr_ptr with wrap.
  - Latch the winner's product, id and number.
  - Latched number = min(req_number, STOCK_CAP).
  - Go to REQ if the latched number is nonzero; otherwise go to ACK (no supplier traffic).
- REQ:
  - sup_valid = 1 with stable sup_product, sup_number and sup_id.
  - Handshake completes on the edge where sup_valid && sup_ready; then go to ACK.
- ACK:
  - req_ready[winner] = 1 for exactly one cycle.
  - Set rr_ptr = (winner + 1) mod NUM_REQ, then return to IDLE.

Timing and handshake rules:
- Latency: request seen at cycle t -> sup_valid from t+1 -> supplier handshake at cycle h -> req_ready pulse at h+1 -> next grant decision at h+2. Minimum turnaround is 3 cycles per request.
- Stores must hold req_valid, req_product and req_number stable until their req_ready pulse.
- The request is latched at grant. A store dropping req_valid after grant does not abort the transaction; its ack is still issued.
- Only one transaction is ever outstanding. Inputs are ignored outside IDLE.
- Simultaneous requests are served strictly round-robin, so no requester waits more than NUM_REQ-1 grants.
- Quantity 63 is clamped to 50; 50 passes through unchanged.
- sup_ready while sup_valid = 0 is ignored.
- req_ready is never asserted for more than one bit or for more than one cycle.

Optional Feature:
- Macro: RESTOCK_TIMEOUT_EN.
- With the macro:
  - A counter runs in REQ.
  - If TIMEOUT_CYC cycles elapse without sup_ready, drop sup_valid, pulse err_timeout for one cycle, skip ACK (the store gets no req_ready), advance rr_ptr past the winner and return to IDLE.
  - The counter clears on entry to REQ.
- Without the macro: no counter; REQ waits indefinitely; err_timeout is tied to 0.

Decomposition:
- Package restock_pkg holds:
  - the state enum (IDLE, REQ, ACK);
  - STOCK_CAP;
  - NUM_W = 6;
  - PROD_A = 1'b1 and PROD_B = 1'b0.
- Sub-module rr_pick: purely combinational round-robin picker (inputs req vector and rr_ptr; outputs grant index and any_valid). It is reused by future store-side schedulers.

Test Plan:
- Single request: store 2 requests product 1, number 17; supplier ready after 3 cycles -> sup_valid=1, sup_id=2, sup_number=17, sup_product=1; req_ready=4'b0100 for 1 cycle; busy low after.
- Contention: all 4 stores request with rr_ptr=0; supplier ready immediately -> grants in order 0,1,2,3; each ack 3 cycles apart; rr_ptr ends at 0.
- Clamp and zero: store 1 number 63 -> sup_number=50. Store 3 number 0 -> req_ready[3] pulse with sup_valid never asserted.
- Reset mid-REQ: assert rst_n=0 while sup_valid=1 -> all outputs 0 immediately; no req_ready pulse; rr_ptr=0 after release.
- Valid withdrawn after grant: store 0 drops req_valid in REQ -> transaction completes and req_ready[0] still pulses.
- With RESTOCK_TIMEOUT_EN: sup_ready held 0 -> err_timeout pulses after 63 REQ cycles; no req_ready; the next pending store is granted.
